// File: rtl/store_trace_checker_if.sv
// CPU data-memory write port as seen by a store checker: one store strobe plus address and data.
// The CPU side drives it, the checker only observes it.
interface store_trace_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/store_trace_checker.sv
// Checks CPU stores against an expected (addr,data) list and latches a sticky PASS/FAIL verdict with cause code.
// Verdict registered one cycle after the deciding store; one store per cycle, no back-pressure.
module store_trace_checker #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_EXP     = 4,
  parameter bit                ORDERED     = 1'b1,
  parameter bit                IGNORE_EN   = 1'b1,
  parameter logic [ADDR_W-1:0] IGNORE_ADDR = 80,
  parameter int                TIMEOUT     = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  store_trace_checker_if.slave       st,
  input  logic [NUM_EXP*ADDR_W-1:0]  exp_addr,
  input  logic [NUM_EXP*DATA_W-1:0]  exp_data,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 fail_code,
  output logic [4:0]                 match_cnt,
  output logic [15:0]                store_cnt,
  output logic [ADDR_W-1:0]          fail_addr,
  output logic [DATA_W-1:0]          fail_data
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t             state;
  logic [NUM_EXP-1:0] hit;
  logic [NUM_EXP-1:0] eq;
  logic [NUM_EXP-1:0] take;
  logic [TW-1:0]      timer;
  logic               any_take;
  logic               any_dup;
  logic               skip;
  logic               last;

  // Case equality so that X/Z on the bus never counts as a match.
  always_comb begin
    eq       = '0;
    take     = '0;
    any_take = 1'b0;
    any_dup  = 1'b0;
    for (int i = 0; i < NUM_EXP; i++) begin
      eq[i] = (st.dataadr === exp_addr[i*ADDR_W +: ADDR_W]) &&
              (st.writedata === exp_data[i*DATA_W +: DATA_W]);
      if (ORDERED) begin
        if (eq[i] && (match_cnt == 5'(i))) begin
          take[i]  = 1'b1;
          any_take = 1'b1;
        end
      end else begin
        if (eq[i] && !hit[i] && !any_take) begin
          take[i]  = 1'b1;
          any_take = 1'b1;
        end
        if (eq[i] && hit[i]) any_dup = 1'b1;
      end
    end
  end

  assign skip = IGNORE_EN && (st.dataadr === IGNORE_ADDR);
  assign last = (5'(match_cnt + 5'd1) == 5'(NUM_EXP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      match_cnt <= 5'd0;
      store_cnt <= 16'd0;
      fail_addr <= '0;
      fail_data <= '0;
      hit       <= '0;
      timer     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state     <= S_RUN;
            match_cnt <= 5'd0;
            store_cnt <= 16'd0;
            hit       <= '0;
            timer     <= '0;
          end
        end
        S_RUN: begin
          if (st.memwrite && (store_cnt != 16'hFFFF)) store_cnt <= store_cnt + 16'd1;
          // Store rules take precedence; the watchdog only fires on a cycle with no store verdict.
          if (st.memwrite && any_take) begin
            match_cnt <= match_cnt + 5'd1;
            hit       <= hit | take;
            timer     <= '0;
            if (last) begin
              state <= S_PASS;
              pass  <= 1'b1;
              done  <= 1'b1;
            end
          end else if (st.memwrite && (any_dup || !skip)) begin
            state     <= S_FAIL;
            fail      <= 1'b1;
            done      <= 1'b1;
            fail_code <= any_dup ? 2'd3 : 2'd1;
            fail_addr <= st.dataadr;
            fail_data <= st.writedata;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state     <= S_FAIL;
            fail      <= 1'b1;
            done      <= 1'b1;
            fail_code <= 2'd2;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_store_trace_checker.sv
// Four checker configurations share one store stream and are compared every cycle against a list-based model.
module tb_store_trace_checker;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] ea [4];
  logic [31:0] ed [4];
  logic [127:0] ea_all, ed_all;
  assign ea_all = {ea[3], ea[2], ea[1], ea[0]};
  assign ed_all = {ed[3], ed[2], ed[1], ed[0]};

  store_trace_checker_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  logic [3:0]  o_done, o_pass, o_fail;
  logic [1:0]  o_code [4];
  logic [4:0]  o_mc   [4];
  logic [15:0] o_sc   [4];
  logic [31:0] o_fa   [4];
  logic [31:0] o_fd   [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // u0: 1 entry ordered, u1: 2 ordered, u2: 2 unordered, u3: 4 unordered
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NE = (g == 0) ? 1 : ((g == 3) ? 4 : 2);
    store_trace_checker #(
      .ADDR_W(32), .DATA_W(32), .NUM_EXP(NE), .ORDERED(g < 2),
      .IGNORE_EN(1'b1), .IGNORE_ADDR(32'd80), .TIMEOUT(TMO)
    ) u (
      .clk(clk), .rst(rst), .en(en), .st(bus),
      .exp_addr(ea_all[NE*32-1:0]), .exp_data(ed_all[NE*32-1:0]),
      .done(o_done[g]), .pass(o_pass[g]), .fail(o_fail[g]),
      .fail_code(o_code[g]), .match_cnt(o_mc[g]), .store_cnt(o_sc[g]),
      .fail_addr(o_fa[g]), .fail_data(o_fd[g])
    );
  end

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 running, 2 passed, 3 failed
  int          m_st   [4];
  int          m_mc   [4];
  int          m_sc   [4];
  int          m_idle [4];
  int          m_code [4];
  logic [31:0] m_fa   [4];
  logic [31:0] m_fd   [4];
  bit          m_used [4][4];

  initial begin
    for (int k = 0; k < 4; k++) m_clear(k);
  end

  function automatic int nexp_of(input int k);
    return (k == 0) ? 1 : ((k == 3) ? 4 : 2);
  endfunction

  task automatic m_clear(input int k);
    m_st[k] = 0; m_mc[k] = 0; m_sc[k] = 0; m_idle[k] = 0; m_code[k] = 0;
    m_fa[k] = 32'd0; m_fd[k] = 32'd0;
    for (int i = 0; i < 4; i++) m_used[k][i] = 1'b0;
  endtask

  task automatic m_failw(input int k, input int code, input logic [31:0] a, input logic [31:0] d);
    m_st[k] = 3; m_code[k] = code; m_fa[k] = a; m_fd[k] = d;
  endtask

  task automatic m_step(input int k);
    int n;
    int found;
    bit dup;
    logic [31:0] a, d;
    n = nexp_of(k);
    a = bus.dataadr;
    d = bus.writedata;
    if (m_st[k] == 0) begin
      if (en) begin
        m_clear(k);
        m_st[k] = 1;
      end
    end else if (m_st[k] == 1) begin
      found = -1;
      dup   = 1'b0;
      if (bus.memwrite) begin
        if (m_sc[k] < 65535) m_sc[k]++;
        if (k < 2) begin
          if (a == ea[m_mc[k]] && d == ed[m_mc[k]]) found = m_mc[k];
        end else begin
          for (int i = n - 1; i >= 0; i--)
            if (a == ea[i] && d == ed[i]) begin
              if (!m_used[k][i]) found = i;
              else dup = 1'b1;
            end
        end
      end
      if (found >= 0) begin
        m_used[k][found] = 1'b1;
        m_mc[k]++;
        m_idle[k] = 0;
        if (m_mc[k] == n) m_st[k] = 2;
      end else if (bus.memwrite && dup) begin
        m_failw(k, 3, a, d);
      end else if (bus.memwrite && a != 32'd80) begin
        m_failw(k, 1, a, d);
      end else begin
        m_idle[k]++;
        if (m_idle[k] == TMO) m_failw(k, 2, 32'd0, 32'd0);
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst) m_clear(k);
      else m_step(k);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s[u%0d] @%0t: got %0d expected %0d", nm, k, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk("done",      k, 64'(o_done[k]), 64'(m_st[k] >= 2));
      chk("pass",      k, 64'(o_pass[k]), 64'(m_st[k] == 2));
      chk("fail",      k, 64'(o_fail[k]), 64'(m_st[k] == 3));
      chk("fail_code", k, 64'(o_code[k]), 64'(m_code[k]));
      chk("match_cnt", k, 64'(o_mc[k]),   64'(m_mc[k]));
      chk("store_cnt", k, 64'(o_sc[k]),   64'(m_sc[k]));
      chk("fail_addr", k, 64'(o_fa[k]),   64'(m_fa[k]));
      chk("fail_data", k, 64'(o_fd[k]),   64'(m_fd[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic e, input logic mw, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en            = e;
    bus.memwrite  = mw;
    bus.dataadr   = a;
    bus.writedata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    tick(1'b0, 1'b1, a, d);
  endtask

  task automatic start();
    tick(1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  // Reset asserted off the clock edges so it never races the negedge compare.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0; en = 1'b0; bus.memwrite = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic std_exp();
    ea[0] = 32'd84; ed[0] = 32'd7;
    ea[1] = 32'd88; ed[1] = 32'd9;
    ea[2] = 32'd92; ed[2] = 32'd11;
    ea[3] = 32'd80; ed[3] = 32'd13;
  endtask

  initial begin
    bus.memwrite = 1'b0; bus.dataadr = 32'd0; bus.writedata = 32'd0;
    std_exp();
    repeat (2) @(negedge clk);
    chk("rst_done", 0, 64'(o_done[0]), 64'd0);
    chk("rst_sc",   3, 64'(o_sc[3]),   64'd0);
    rst = 1'b1;

    // ignored scratch stores then the one expected store
    do_reset(); start();
    store(32'd80, 32'd3); store(32'd80, 32'd5); store(32'd84, 32'd7); idle(1);
    chk("t1_pass", 0, 64'(o_pass[0]), 64'd1);
    chk("t1_mc",   0, 64'(o_mc[0]),   64'd1);
    chk("t1_sc",   0, 64'(o_sc[0]),   64'd3);
    chk("t1_code", 0, 64'(o_code[0]), 64'd0);

    // mismatch is sticky
    do_reset(); start();
    store(32'd88, 32'd7); idle(1);
    chk("t2_fail", 0, 64'(o_fail[0]), 64'd1);
    chk("t2_code", 0, 64'(o_code[0]), 64'd1);
    chk("t2_fa",   0, 64'(o_fa[0]),   64'd88);
    chk("t2_fd",   0, 64'(o_fd[0]),   64'd7);
    store(32'd84, 32'd7); idle(1);
    chk("t2_sticky_code", 0, 64'(o_code[0]), 64'd1);
    chk("t2_sticky_pass", 0, 64'(o_pass[0]), 64'd0);

    // out-of-order stores: ordered fails, unordered passes
    do_reset(); start();
    store(32'd88, 32'd9); store(32'd84, 32'd7); idle(1);
    chk("t3_ord_code", 1, 64'(o_code[1]), 64'd1);
    chk("t3_ord_fa",   1, 64'(o_fa[1]),   64'd88);
    chk("t3_uno_pass", 2, 64'(o_pass[2]), 64'd1);
    chk("t3_uno_mc",   2, 64'(o_mc[2]),   64'd2);

    // duplicate in unordered mode
    do_reset(); start();
    store(32'd84, 32'd7); store(32'd84, 32'd7); idle(1);
    chk("t4_code", 2, 64'(o_code[2]), 64'd3);
    chk("t4_fa",   2, 64'(o_fa[2]),   64'd84);

    // watchdog fires exactly TMO cycles after RUN entry
    do_reset(); start();
    idle(TMO);
    chk("t5_nofail_yet", 0, 64'(o_fail[0]), 64'd0);
    idle(1);
    chk("t5_fail", 0, 64'(o_fail[0]), 64'd1);
    chk("t5_code", 0, 64'(o_code[0]), 64'd2);
    chk("t5_fa",   0, 64'(o_fa[0]),   64'd0);

    // match on the expiry cycle wins and restarts the timer
    do_reset(); start();
    idle(TMO - 1); store(32'd84, 32'd7); idle(1);
    chk("t5b_pass",   0, 64'(o_pass[0]), 64'd1);
    chk("t5b_mc",     1, 64'(o_mc[1]),   64'd1);
    chk("t5b_nofail", 1, 64'(o_fail[1]), 64'd0);
    idle(TMO - 1);
    chk("t5b_nofail2", 1, 64'(o_fail[1]), 64'd0);
    idle(1);
    chk("t5b_code", 1, 64'(o_code[1]), 64'd2);

    // asynchronous reset mid-run, then a clean pass
    do_reset(); start();
    store(32'd84, 32'd7); idle(2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_mc",   1, 64'(o_mc[1]),   64'd0);
    chk("t6_sc",   1, 64'(o_sc[1]),   64'd0);
    chk("t6_done", 1, 64'(o_done[1]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    start(); store(32'd84, 32'd7); store(32'd88, 32'd9); idle(1);
    chk("t6_pass", 1, 64'(o_pass[1]), 64'd1);
    chk("t6_sc2",  1, 64'(o_sc[1]),   64'd2);

    // randomized traces over a small address/data pool to provoke matches, dups and timeouts
    for (int it = 0; it < 80; it++) begin
      int idle_pct;
      for (int i = 0; i < 4; i++) begin
        ea[i] = 32'd80 + 32'(4 * $urandom_range(0, 3));
        ed[i] = 32'($urandom_range(0, 3));
      end
      do_reset(); start();
      idle_pct = (it % 3 == 0) ? 92 : 35;
      for (int c = 0; c < 40; c++) begin
        int j;
        logic [31:0] a, d;
        if ($urandom_range(0, 99) < idle_pct) begin
          tick(1'($urandom_range(0, 1)), 1'b0, $urandom, $urandom);
        end else begin
          if ($urandom_range(0, 1) == 1) begin
            j = int'($urandom_range(0, 3));
            a = ea[j]; d = ed[j];
          end else begin
            a = 32'd80 + 32'(4 * $urandom_range(0, 3));
            d = 32'($urandom_range(0, 3));
          end
          tick(1'($urandom_range(0, 1)), 1'b1, a, d);
        end
      end
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
